// File: rtl/count_event_pkg.sv
// Shared constants for the count event logger: event codes, event width and
// the default reload value of the monitored counter.
package count_event_pkg;

  localparam logic [1:0] EVT_WRAP   = 2'b01;
  localparam logic [1:0] EVT_RELOAD = 2'b10;
  localparam logic [1:0] EVT_JUMP   = 2'b11;

  localparam int DEF_RELOAD_VAL = 10;

  function automatic int evt_width(input int ts_w);
    return 2 + ts_w;
  endfunction

endpackage

// File: rtl/count_event_logger_if.sv
// Valid/ready event stream from the logger to a consumer; each beat carries
// {code, timestamp}.
interface count_event_logger_if
  import count_event_pkg::*;
#(
  parameter int TS_W = 8
) ();

  logic                       evt_valid;
  logic                       evt_ready;
  logic [evt_width(TS_W)-1:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);

endinterface

// File: rtl/count_event_logger_sync_fifo.sv
// Reusable single-clock FIFO. A push into a full FIFO is taken only when a
// pop happens in the same cycle; a pop on an empty FIFO is ignored.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/count_event_logger.sv
// Monitors a free-running reload counter, classifies each step and queues
// timestamped wrap/reload/jump events for a valid/ready consumer.
module count_event_logger
  import count_event_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int RELOAD_VAL = DEF_RELOAD_VAL,
  parameter int TS_W       = 8,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CNT_W-1:0]             cnt_in,
  count_event_logger_if.master         evt,
  output logic                         overflow
);

  localparam int EW = evt_width(TS_W);

  logic [CNT_W-1:0] prev_r;
  logic             primed_r;
  logic [TS_W-1:0]  ts_r;
  logic             overflow_r;

  logic [CNT_W-1:0] exp_s;
  logic             evt_s;
  logic [1:0]       code_s;
  logic             full_s;
  logic             empty_s;
  logic             drop_s;
  logic [EW-1:0]    rdata_s;

  assign exp_s = prev_r + CNT_W'(1);

  // Step classifier; priority is hold, increment/wrap, reload, jump.
  always_comb begin
    evt_s  = 1'b0;
    code_s = 2'b00;
    if (!primed_r || (cnt_in == prev_r)) begin
      evt_s  = 1'b0;
    end else if (cnt_in == exp_s) begin
      if (prev_r == {CNT_W{1'b1}}) begin
        evt_s  = 1'b1;
        code_s = EVT_WRAP;
      end else begin
        evt_s  = 1'b0;
      end
    end else if (cnt_in == CNT_W'(RELOAD_VAL)) begin
      evt_s  = 1'b1;
      code_s = EVT_RELOAD;
    end else begin
      evt_s  = 1'b1;
      code_s = EVT_JUMP;
    end
  end

  // A full FIFO only frees a slot this cycle if the consumer takes the head.
  assign drop_s = evt_s && full_s && !evt.evt_ready;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt_s),
    .pop   (evt.evt_ready),
    .wdata ({code_s, ts_r}),
    .rdata (rdata_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Sample history, free-running timestamp and sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r     <= '0;
      primed_r   <= 1'b0;
      ts_r       <= '0;
      overflow_r <= 1'b0;
    end else begin
      prev_r     <= cnt_in;
      primed_r   <= 1'b1;
      ts_r       <= ts_r + TS_W'(1);
      overflow_r <= overflow_r | drop_s;
    end
  end

  assign evt.evt_valid = !empty_s;
  assign evt.evt_data  = rdata_s;
  assign overflow      = overflow_r;

endmodule

// File: tb/tb_count_event_logger.sv
// Scoreboard bench for count_event_logger: a reference model pushes expected
// events at drive time and pops them when the DUT hands over its FIFO head.
module tb_count_event_logger;
  import count_event_pkg::*;

  localparam int CNT_W  = 4;
  localparam int TS_W   = 8;
  localparam int DEPTH  = 4;
  localparam int RELOAD = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] cnt_in;
  logic             overflow;

  count_event_logger_if #(.TS_W(TS_W)) bus ();

  count_event_logger #(
    .CNT_W      (CNT_W),
    .RELOAD_VAL (RELOAD),
    .TS_W       (TS_W),
    .DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_in   (cnt_in),
    .evt      (bus),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  logic [TS_W+1:0]  sb_q[$];
  logic [CNT_W-1:0] m_prev;
  logic             m_primed;
  logic [TS_W-1:0]  m_ts;
  logic             m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_prev   = '0;
    m_primed = 1'b0;
    m_ts     = '0;
    m_ovf    = 1'b0;
  endtask

  // One clock cycle: drive, check current outputs, update model, advance.
  task automatic step(input logic [CNT_W-1:0] c, input logic r);
    logic [CNT_W-1:0] e;
    logic             ev;
    logic [1:0]       code;
    logic [TS_W+1:0]  exp_data;
    cnt_in        = c;
    bus.evt_ready = r;
    check_eq("valid", 32'(bus.evt_valid), 32'(sb_q.size() > 0));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    if (r && bus.evt_valid) pops++;
    if (r && sb_q.size() > 0) begin
      exp_data = sb_q.pop_front();
      check_eq("data", 32'(bus.evt_data), 32'(exp_data));
    end
    ev   = 1'b0;
    code = 2'b00;
    e    = m_prev + 4'd1;
    if (m_primed && c != m_prev) begin
      if (c == e) begin
        if (m_prev == 4'hF) begin
          ev   = 1'b1;
          code = 2'b01;
        end
      end else if (c == 4'(RELOAD)) begin
        ev   = 1'b1;
        code = 2'b10;
      end else begin
        ev   = 1'b1;
        code = 2'b11;
      end
    end
    if (ev) begin
      if (sb_q.size() < DEPTH) sb_q.push_back({code, m_ts});
      else m_ovf = 1'b1;
    end
    m_prev   = c;
    m_primed = 1'b1;
    m_ts     = m_ts + 8'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.evt_valid), 32'd0);
    check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
    check_eq({tag, "_data"}, 32'(bus.evt_data), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    reset_check("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    cnt_in        = 4'd0;
    bus.evt_ready = 1'b0;
    model_reset();
    do_reset();

    // Normal counting through one wrap.
    pops = 0;
    for (int i = 0; i < 8; i++) step(4'((10 + i) % 16), 1'b1);
    for (int i = 0; i < 3; i++) step(4'd1, 1'b1);
    check_eq("wrap_count", 32'(pops), 32'd1);

    // 1->12 jump, 13->10 reload.
    pops = 0;
    step(4'd12, 1'b1); step(4'd13, 1'b1); step(4'd10, 1'b1); step(4'd11, 1'b1);
    for (int i = 0; i < 3; i++) step(4'd11, 1'b1);
    check_eq("reload_count", 32'(pops), 32'd2);

    // 11->5 and 5->9 jumps, then 9->7 jump and a hold on 7.
    pops = 0;
    step(4'd5, 1'b1); step(4'd9, 1'b1); step(4'd7, 1'b1); step(4'd7, 1'b1);
    for (int i = 0; i < 3; i++) step(4'd7, 1'b1);
    check_eq("jump_count", 32'(pops), 32'd3);

    // Fill with four wraps, then full + pop + event on the fifth: no drop.
    do_reset();
    for (int i = 0; i < 80; i++) step(4'(i), 1'b0);
    step(4'd0, 1'b1);
    check_eq("full_pop_ovf", 32'(overflow), 32'd0);
    for (int i = 81; i < 97; i++) step(4'(i), 1'b0);
    check_eq("drop_ovf", 32'(overflow), 32'd1);
    check_eq("drop_valid", 32'(bus.evt_valid), 32'd1);
    pops = 0;
    for (int i = 0; i < 6; i++) step(4'd0, 1'b1);
    check_eq("drain_count", 32'(pops), 32'd4);

    // Overfill with jumps, leave three queued, then reset mid-stream.
    step(4'd3, 1'b0); step(4'd9, 1'b0); step(4'd1, 1'b0);
    step(4'd5, 1'b0); step(4'd12, 1'b0);
    step(4'd12, 1'b1);
    step(4'd12, 1'b0);
    check_eq("pre_rst_ovf", 32'(overflow), 32'd1);
    rst = 1'b1;
    #1;
    reset_check("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    pops = 0;
    step(4'd10, 1'b1); step(4'd11, 1'b1); step(4'd12, 1'b1); step(4'd12, 1'b1);
    check_eq("post_rst_count", 32'(pops), 32'd0);

    // Timestamp wrap: events at ts 255 and ts 3.
    pops = 0;
    while (m_ts != 8'd255) step(4'd12, 1'b1);
    step(4'd2, 1'b1);
    while (m_ts != 8'd3) step(4'd2, 1'b1);
    step(4'd8, 1'b1);
    for (int i = 0; i < 3; i++) step(4'd8, 1'b1);
    check_eq("ts_wrap_count", 32'(pops), 32'd2);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
